ball_collision_detector: RTL
============================

Name: ball_collision_detector

Overview:
Consumer of the per-pixel drawingRequest outputs from the ball, player, rope and border bitmap blocks. Each pixel cycle it detects coincident requests (overlap) and accumulates them over one video frame. At each frame boundary it reports them as single-cycle event pulses to the game-control logic. It also provides a frame-counted player invulnerability window after a player hit.

Parameters:
NUM_BALLS, 4, number of ball bitmap instances monitored.
INVULN_FRAMES, 60, number of frames player hits are suppressed after a reported player hit; legal range 1..255.

Ports:
clk  in  1  pixel clock.
resetN  in  1  asynchronous active-low reset.
startOfFrame  in  1  single-cycle pulse marking the first pixel of a frame.
ballDrawingRequest  in  NUM_BALLS  per-ball drawingRequest, bit i = ball i.
playerDrawingRequest  in  1  player bitmap drawingRequest.
ropeDrawingRequest  in  1  rope bitmap drawingRequest.
borderDrawingRequest  in  1  border/wall drawingRequest.
ballHitRope  out  NUM_BALLS  one-hot one-cycle pulse: ball popped by rope in the previous frame.
ballHitBorder  out  NUM_BALLS  one-cycle pulse per ball that touched the border in the previous frame.
playerHit  out  1  one-cycle pulse: player touched any ball in the previous frame (not suppressed).
invulnerable  out  1  level, high while in INVULN state.
popCount  out  8  running count of reported rope pops, saturating.

Behaviour:
- Reset (async, resetN=0): all outputs 0, pending flags cleared, state ACTIVE, invulnerability counter 0, popCount 0. Reset mid-frame discards all pending detections.
- Per-cycle detection (combinational on the inputs):
  - rope_i = ballDrawingRequest[i] & ropeDrawingRequest.
  - border_i = ballDrawingRequest[i] & borderDrawingRequest.
  - player_x = playerDrawingRequest & |ballDrawingRequest.
- Accumulation: sticky pend_rope[i], pend_border[i] and pend_player are ORed with the detections every cycle in which startOfFrame=0.
- Frame boundary (startOfFrame=1), all on the same clock edge:
  - Outputs load from the pending flags. The current cycle's detections belong to the new frame: pending flags load with the current detections only, not with an OR of old and new.
- Output latency: pulses are registered and are high exactly one cycle, the cycle after the startOfFrame edge. They are 0 in all other cycles.
- Rope arbitration: at most one ballHitRope bit set per frame. The lowest-index ball with pend_rope set wins; other rope pends for that frame are dropped.
- ballHitBorder is not arbitrated; multiple bits may be set.
- popCount increments by 1 whenever ballHitRope is nonzero, saturating at 255. It never wraps.
- Invulnerability FSM, 8-bit counter cnt:
  - ACTIVE: at startOfFrame with pend_player=1, playerHit pulses, cnt<=INVULN_FRAMES, next state INVULN. Otherwise stay in ACTIVE with playerHit=0.
  - INVULN: pend_player is discarded at each startOfFrame and playerHit stays 0. At each startOfFrame, if cnt==1, next state ACTIVE and cnt<=0; else cnt<=cnt-1.
  - invulnerable=1 exactly while state==INVULN (registered, same edge as the playerHit pulse).
  - Consequence: the INVULN state spans INVULN_FRAMES frame boundaries. The first frame whose hits can be reported again is the one starting at the boundary where the FSM returns to ACTIVE.
- Simultaneous events in one frame: rope, border and player reports are independent and may pulse on the same cycle.
- Consecutive startOfFrame pulses with no cycle between them are legal. Each boundary reports whatever accumulated since the previous one.
- No detection while no startOfFrame ever arrives: pends stay sticky and nothing is reported.

Test Plan:
1. Reset: hold resetN=0 with all request inputs=1 -> all outputs 0; after release, popCount=0 and invulnerable=0.
2. Rope pop:
   - Stimulus: ball 2 and rope both high for 3 cycles mid-frame, then startOfFrame.
   - Required: ballHitRope=4'b0100 for exactly one cycle after the boundary; popCount=1; next frame with no overlap gives ballHitRope=0.
3. Arbitration:
   - Stimulus: balls 1 and 3 overlap the rope in the same frame.
   - Required: ballHitRope=4'b0010 only; popCount+1. Same frame with balls 0 and 2 touching the border gives ballHitBorder=4'b0101 on the same cycle.
4. Boundary ownership: ball 0 overlaps the rope only in the cycle where startOfFrame=1 -> no pulse at that boundary; ballHitRope=4'b0001 at the following boundary.
5. Invulnerability, INVULN_FRAMES=3:
   - Stimulus: player overlaps a ball in every frame.
   - Required: playerHit pulses at boundary k; invulnerable=1 from k until it clears at boundary k+3; next playerHit at boundary k+4.
6. Saturation/reset: 260 pop frames -> popCount holds 255. Asserting resetN mid-frame with pend_player set -> no playerHit at the next boundary.

Source files
------------

// File: rtl/ball_collision_detector.sv
// Frame-accumulated overlap detector for ball/player/rope/border bitmaps.
// Reports collisions as one-cycle pulses after each frame boundary.
module ball_collision_detector #(
    parameter int NUM_BALLS     = 4,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS-1:0] ballDrawingRequest,
    input  logic                 playerDrawingRequest,
    input  logic                 ropeDrawingRequest,
    input  logic                 borderDrawingRequest,
    output logic [NUM_BALLS-1:0] ballHitRope,
    output logic [NUM_BALLS-1:0] ballHitBorder,
    output logic                 playerHit,
    output logic                 invulnerable,
    output logic [7:0]           popCount
);

    typedef enum logic {
        ACTIVE,
        INVULN
    } state_t;

    localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);

    state_t               state;
    state_t               state_n;
    logic [7:0]           cnt;
    logic [7:0]           cnt_n;
    logic                 hit_n;

    logic [NUM_BALLS-1:0] rope_det;
    logic [NUM_BALLS-1:0] border_det;
    logic                 player_det;

    logic [NUM_BALLS-1:0] pend_rope;
    logic [NUM_BALLS-1:0] pend_border;
    logic                 pend_player;
    logic [NUM_BALLS-1:0] rope_win;

    assign rope_det   = ballDrawingRequest & {NUM_BALLS{ropeDrawingRequest}};
    assign border_det = ballDrawingRequest & {NUM_BALLS{borderDrawingRequest}};
    assign player_det = playerDrawingRequest & (|ballDrawingRequest);

    // Isolate the lowest set bit: only one ball pops per frame.
    assign rope_win = pend_rope & (~pend_rope + NUM_BALLS'(1));

    assign invulnerable = (state == INVULN);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hit_n   = 1'b0;
        if (startOfFrame) begin
            unique case (state)
                ACTIVE: begin
                    if (pend_player) begin
                        hit_n   = 1'b1;
                        cnt_n   = INV_LOAD;
                        state_n = INVULN;
                    end
                end
                INVULN: begin
                    if (cnt == 8'd1) begin
                        cnt_n   = 8'd0;
                        state_n = ACTIVE;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
                default: begin
                    state_n = ACTIVE;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ACTIVE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Detections on the boundary cycle belong to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_rope   <= '0;
            pend_border <= '0;
            pend_player <= 1'b0;
        end else if (startOfFrame) begin
            pend_rope   <= rope_det;
            pend_border <= border_det;
            pend_player <= player_det;
        end else begin
            pend_rope   <= pend_rope | rope_det;
            pend_border <= pend_border | border_det;
            pend_player <= pend_player | player_det;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ballHitRope   <= '0;
            ballHitBorder <= '0;
            playerHit     <= 1'b0;
        end else begin
            ballHitRope   <= startOfFrame ? rope_win : '0;
            ballHitBorder <= startOfFrame ? pend_border : '0;
            playerHit     <= hit_n;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            popCount <= 8'd0;
        end else if ((|ballHitRope) && (popCount != 8'hFF)) begin
            popCount <= popCount + 8'd1;
        end
    end

endmodule
